branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised branch predictor for the 5-stage pipelined core. It combines a branch history table of 2-bit saturating counters with a tagged branch target buffer.
- Lookup is combinational in IF and drives the next-PC choice, so taken branches redirect without waiting for ID resolution.
- Updates come from the ID-stage branch resolution.
- MODE selects bimodal or gshare indexing. Saturating statistics counters are kept for performance measurement.

Parameters:
- ADDR_W, 32: PC / target width.
- ENTRIES, 64: table depth; power of two, >=2. IDX_W = log2(ENTRIES).
- TAG_W, 8: BTB tag width. Requires ADDR_W >= IDX_W+TAG_W+2.
- MODE, 0: 0 = bimodal, 1 = gshare.
- HIST_W, 6: global history width; 1..IDX_W. Used only when MODE=1.
- CNT_W, 16: statistics counter width.

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: synchronous reset, active-low.
- lookup_pc_i, input, ADDR_W: IF-stage PC.
- pred_hit_o, output, 1: BTB valid and tag match.
- pred_taken_o, output, 1: predicted taken.
- pred_target_o, output, ADDR_W: predicted next PC.
- pred_hist_o, output, HIST_W: current GHR, carried down the pipe with the branch.
- update_valid_i, input, 1: resolved branch present this cycle.
- update_pc_i, input, ADDR_W: PC of the resolved branch.
- update_hist_i, input, HIST_W: GHR value captured at that branch's lookup.
- update_taken_i, input, 1: actual outcome.
- update_target_i, input, ADDR_W: actual taken target.
- update_pred_taken_i, input, 1: prediction that was made for the branch.
- branch_cnt_o, output, CNT_W: resolved branches.
- mispred_cnt_o, output, CNT_W: direction mispredictions.

Behaviour:
- Index and tag:
  - base = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - MODE=0: idx = base.
  - MODE=1: idx = base XOR zero-extended GHR. Lookups use the current GHR; updates use update_hist_i.
- Storage per entry: valid (1), tag (TAG_W), target (ADDR_W), counter (2). Register- or array-based.
- Lookup (combinational, zero latency):
  - pred_hit_o = valid[idx] && tag match.
  - pred_taken_o = pred_hit_o && cnt[idx][1].
  - pred_target_o = pred_taken_o ? target[idx] : lookup_pc_i+4, modulo 2^ADDR_W (0xFFFFFFFC+4 = 0).
- Update, at the rising edge with update_valid_i=1:
  - Hit, taken: counter increments, saturating at 2'b11; target is overwritten with update_target_i.
  - Hit, not taken: counter decrements, saturating at 2'b00; target unchanged.
  - Miss, taken: allocate/replace. valid=1, tag, target written, counter = 2'b10.
  - Miss, not taken: no table change.
  - GHR, MODE=1: GHR <= {GHR[HIST_W-2:0], update_taken_i} on every valid update, hit or miss. For HIST_W=1, GHR <= update_taken_i.
  - GHR, MODE=0: GHR held at 0.
  - branch_cnt_o increments by 1.
  - mispred_cnt_o increments when update_pred_taken_i != update_taken_i.
  - Both counters saturate at all-ones and do not wrap.
- update_valid_i=0: no state change.
- Simultaneous lookup and update to the same entry: lookup returns the pre-update contents (read-old). The new value is visible the cycle after the edge.
- Reset (rst_i=0 at a rising edge):
  - All valid=0, counters=2'b01, tags/targets=0, GHR=0, both stat counters=0.
  - Reset overrides a concurrent update_valid_i; nothing is allocated.
  - Outputs after reset: pred_hit_o=0, pred_taken_o=0, pred_target_o=lookup_pc_i+4, pred_hist_o=0, branch_cnt_o=0, mispred_cnt_o=0.
- No flush port. The table is a hint only, so correctness never depends on its contents.

Test Plan:
1. Reset, then lookup 0x100 -> hit=0, taken=0, target=0x104, hist=0, counters=0.
2. Update pc=0x100 taken target=0x80 pred_taken=0 -> next cycle, lookup 0x100 gives hit=1, taken=1, target=0x80; branch_cnt=1, mispred_cnt=1.
3. From scenario 2:
   - Not-taken update on 0x100 -> counter 01, taken=0, target=0x104.
   - Second not-taken update -> counter 00.
   - Three taken updates -> 01, 10, 11; taken=1.
   - Fourth taken update -> counter stays 11.
4. Aliasing (ENTRIES=64, TAG_W=8): 0x100 allocated -> lookup 0x200 (same idx 0, tag 0x02 vs 0x01) gives hit=0, target=0x204. Taken update on 0x200 target 0x40 -> 0x200 hits, 0x100 misses.
5. MODE=1, HIST_W=6:
   - Three taken updates on 0x400 -> pred_hist_o=6'b000111.
   - Lookup 0x400 uses idx 0x00^0x07=0x07, which is not yet allocated -> hit=0.
   - Taken update with update_hist_i=0x07 target 0x10 -> next lookup 0x400 with GHR 0x0F does not hit idx 0x07, confirming the history XOR.
6. Concurrency and reset:
   - Same-cycle lookup/update on 0x100 -> old value seen that cycle, new value the next cycle.
   - rst_i=0 concurrent with update_valid_i=1 -> no allocation, all counters 0.
   - CNT_W=4 with 20 mispredicted updates -> mispred_cnt_o=0xF, branch_cnt_o=0xF.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Predictor-facing bundle: IF-stage lookup, ID-stage resolution and the
// statistics readout. The pipeline is the master, the predictor the slave.
interface branch_predictor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned HIST_W = 6,
  parameter int unsigned CNT_W  = 16
);
  // Lookup side
  logic [ADDR_W-1:0] lookup_pc_i;
  logic              pred_hit_o;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_target_o;
  logic [HIST_W-1:0] pred_hist_o;

  // Update handshake: update_valid_i is a single-cycle qualifier with no
  // ready. Every rising edge that sees it high consumes exactly one resolved
  // branch described by the other update_* fields; the predictor can never
  // stall the pipeline, so there is no back-pressure.
  logic              update_valid_i;
  logic [ADDR_W-1:0] update_pc_i;
  logic [HIST_W-1:0] update_hist_i;
  logic              update_taken_i;
  logic [ADDR_W-1:0] update_target_i;
  logic              update_pred_taken_i;

  // Statistics
  logic [CNT_W-1:0]  branch_cnt_o;
  logic [CNT_W-1:0]  mispred_cnt_o;

  modport master (
    output lookup_pc_i,
    input  pred_hit_o, pred_taken_o, pred_target_o, pred_hist_o,
    output update_valid_i, update_pc_i, update_hist_i, update_taken_i,
    output update_target_i, update_pred_taken_i,
    input  branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  lookup_pc_i,
    output pred_hit_o, pred_taken_o, pred_target_o, pred_hist_o,
    input  update_valid_i, update_pc_i, update_hist_i, update_taken_i,
    input  update_target_i, update_pred_taken_i,
    output branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Branch predictor: 2-bit saturating direction counters plus a tagged BTB,
// bimodal (MODE=0) or gshare (MODE=1) indexed. Lookup is combinational and
// reads the pre-update contents; updates land at the rising edge.
module branch_predictor #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned MODE    = 0,
  parameter int unsigned HIST_W  = 6,
  parameter int unsigned CNT_W   = 16
) (
  input logic clk_i,
  input logic rst_i,
  branch_predictor_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic              validQ  [ENTRIES];
  logic [TAG_W-1:0]  tagQ    [ENTRIES];
  logic [ADDR_W-1:0] targetQ [ENTRIES];
  logic [1:0]        cntQ    [ENTRIES];
  logic [HIST_W-1:0] ghrQ;
  logic [CNT_W-1:0]  branchCnt;
  logic [CNT_W-1:0]  mispredCnt;

  logic [IDX_W-1:0]  lookupBase, lookupIdx, updBase, updIdx;
  logic [TAG_W-1:0]  lookupTag, updTag;
  logic              lookupHit, lookupTaken, updHit;
  logic              unusedBits;

  // Index/tag extraction; gshare folds history into the low index bits.
  assign lookupBase = bus.lookup_pc_i[IDX_W+1:2];
  assign lookupTag  = bus.lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign updBase    = bus.update_pc_i[IDX_W+1:2];
  assign updTag     = bus.update_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign lookupIdx  = (MODE == 1) ? (lookupBase ^ IDX_W'(ghrQ)) : lookupBase;
  assign updIdx     = (MODE == 1) ? (updBase ^ IDX_W'(bus.update_hist_i)) : updBase;

  // PC alignment bits and upper PC bits do not take part in indexing.
  assign unusedBits = ^{bus.lookup_pc_i, bus.update_pc_i, bus.update_hist_i};

  // Combinational lookup against the current (pre-edge) table contents.
  always_comb begin
    lookupHit   = validQ[lookupIdx] && (tagQ[lookupIdx] == lookupTag);
    lookupTaken = lookupHit && cntQ[lookupIdx][1];
    updHit      = validQ[updIdx] && (tagQ[updIdx] == updTag);
  end

  assign bus.pred_hit_o    = lookupHit;
  assign bus.pred_taken_o  = lookupTaken;
  assign bus.pred_target_o = lookupTaken ? targetQ[lookupIdx]
                                         : bus.lookup_pc_i + ADDR_W'(4);
  assign bus.pred_hist_o   = ghrQ;
  assign bus.branch_cnt_o  = branchCnt;
  assign bus.mispred_cnt_o = mispredCnt;

  // Table, history and statistics update from the resolved branch.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        targetQ[i] <= '0;
        cntQ[i]    <= 2'b01;
      end
      ghrQ       <= '0;
      branchCnt  <= '0;
      mispredCnt <= '0;
    end else if (bus.update_valid_i) begin
      if (updHit) begin
        if (bus.update_taken_i) begin
          if (cntQ[updIdx] != 2'b11) cntQ[updIdx] <= cntQ[updIdx] + 2'd1;
          targetQ[updIdx] <= bus.update_target_i;
        end else if (cntQ[updIdx] != 2'b00) begin
          cntQ[updIdx] <= cntQ[updIdx] - 2'd1;
        end
      end else if (bus.update_taken_i) begin
        // Miss on a taken branch replaces whatever occupied the slot.
        validQ[updIdx]  <= 1'b1;
        tagQ[updIdx]    <= updTag;
        targetQ[updIdx] <= bus.update_target_i;
        cntQ[updIdx]    <= 2'b10;
      end
      // Truncating cast gives {ghr[HIST_W-2:0], taken}, also for HIST_W=1.
      if (MODE == 1) ghrQ <= HIST_W'({ghrQ, bus.update_taken_i});
      if (branchCnt != '1) branchCnt <= branchCnt + CNT_W'(1);
      if ((bus.update_pred_taken_i != bus.update_taken_i) && (mispredCnt != '1))
        mispredCnt <= mispredCnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: bimodal instance, gshare instance and
// a narrow-statistics instance, checked with immediate assertions.
module tb_branch_predictor;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  branch_predictor_if #(.ADDR_W(32), .HIST_W(6), .CNT_W(16)) bus0 ();
  branch_predictor_if #(.ADDR_W(32), .HIST_W(6), .CNT_W(16)) bus1 ();
  branch_predictor_if #(.ADDR_W(32), .HIST_W(6), .CNT_W(4))  bus2 ();

  branch_predictor #(.MODE(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  branch_predictor #(.MODE(1), .HIST_W(6)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
  branch_predictor #(.CNT_W(4)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idleAll();
    bus0.update_valid_i = 1'b0; bus1.update_valid_i = 1'b0; bus2.update_valid_i = 1'b0;
    bus0.update_pc_i = '0; bus1.update_pc_i = '0; bus2.update_pc_i = '0;
    bus0.update_hist_i = '0; bus1.update_hist_i = '0; bus2.update_hist_i = '0;
    bus0.update_taken_i = 1'b0; bus1.update_taken_i = 1'b0; bus2.update_taken_i = 1'b0;
    bus0.update_target_i = '0; bus1.update_target_i = '0; bus2.update_target_i = '0;
    bus0.update_pred_taken_i = 1'b0; bus1.update_pred_taken_i = 1'b0;
    bus2.update_pred_taken_i = 1'b0;
    bus0.lookup_pc_i = '0; bus1.lookup_pc_i = '0; bus2.lookup_pc_i = '0;
  endtask

  // One update cycle on the selected instance; returns at the following negedge.
  task automatic doUpdate(input int sel, input logic [31:0] pc, input logic [5:0] hist,
                          input logic taken, input logic [31:0] target, input logic predTaken);
    @(negedge clk);
    case (sel)
      0: begin
        bus0.update_valid_i = 1'b1; bus0.update_pc_i = pc; bus0.update_hist_i = hist;
        bus0.update_taken_i = taken; bus0.update_target_i = target;
        bus0.update_pred_taken_i = predTaken;
      end
      1: begin
        bus1.update_valid_i = 1'b1; bus1.update_pc_i = pc; bus1.update_hist_i = hist;
        bus1.update_taken_i = taken; bus1.update_target_i = target;
        bus1.update_pred_taken_i = predTaken;
      end
      default: begin
        bus2.update_valid_i = 1'b1; bus2.update_pc_i = pc; bus2.update_hist_i = hist;
        bus2.update_taken_i = taken; bus2.update_target_i = target;
        bus2.update_pred_taken_i = predTaken;
      end
    endcase
    @(negedge clk);
    bus0.update_valid_i = 1'b0; bus1.update_valid_i = 1'b0; bus2.update_valid_i = 1'b0;
  endtask

  task automatic lookup(input int sel, input logic [31:0] pc);
    case (sel)
      0: bus0.lookup_pc_i = pc;
      1: bus1.lookup_pc_i = pc;
      default: bus2.lookup_pc_i = pc;
    endcase
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idleAll();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset state
    lookup(0, 32'h100);
    check("rst_hit", 32'(bus0.pred_hit_o), 32'd0);
    check("rst_taken", 32'(bus0.pred_taken_o), 32'd0);
    check("rst_target", bus0.pred_target_o, 32'h104);
    check("rst_hist", 32'(bus0.pred_hist_o), 32'd0);
    check("rst_bcnt", 32'(bus0.branch_cnt_o), 32'd0);
    check("rst_mcnt", 32'(bus0.mispred_cnt_o), 32'd0);
    lookup(0, 32'hFFFF_FFFC);
    check("wrap_target", bus0.pred_target_o, 32'h0);
    lookup(1, 32'h400);
    check("g_rst_hist", 32'(bus1.pred_hist_o), 32'd0);

    // Allocate 0x100 -> 0x80, counter 10
    doUpdate(0, 32'h100, 6'd0, 1'b1, 32'h80, 1'b0);
    lookup(0, 32'h100);
    check("alloc_hit", 32'(bus0.pred_hit_o), 32'd1);
    check("alloc_taken", 32'(bus0.pred_taken_o), 32'd1);
    check("alloc_target", bus0.pred_target_o, 32'h80);
    check("alloc_bcnt", 32'(bus0.branch_cnt_o), 32'd1);
    check("alloc_mcnt", 32'(bus0.mispred_cnt_o), 32'd1);

    // Counter walk: 10 -> 01 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10
    doUpdate(0, 32'h100, 6'd0, 1'b0, 32'h0, 1'b1);
    lookup(0, 32'h100);
    check("nt1_hit", 32'(bus0.pred_hit_o), 32'd1);
    check("nt1_taken", 32'(bus0.pred_taken_o), 32'd0);
    check("nt1_target", bus0.pred_target_o, 32'h104);
    doUpdate(0, 32'h100, 6'd0, 1'b0, 32'h0, 1'b0);
    lookup(0, 32'h100);
    check("nt2_taken", 32'(bus0.pred_taken_o), 32'd0);
    doUpdate(0, 32'h100, 6'd0, 1'b1, 32'h80, 1'b0);
    lookup(0, 32'h100);
    check("t1_taken", 32'(bus0.pred_taken_o), 32'd0);
    doUpdate(0, 32'h100, 6'd0, 1'b1, 32'h80, 1'b0);
    lookup(0, 32'h100);
    check("t2_taken", 32'(bus0.pred_taken_o), 32'd1);
    check("t2_target", bus0.pred_target_o, 32'h80);
    doUpdate(0, 32'h100, 6'd0, 1'b1, 32'h80, 1'b1);
    doUpdate(0, 32'h100, 6'd0, 1'b1, 32'h80, 1'b1);
    doUpdate(0, 32'h100, 6'd0, 1'b0, 32'h0, 1'b1);
    lookup(0, 32'h100);
    check("sat_taken", 32'(bus0.pred_taken_o), 32'd1);
    check("sat_bcnt", 32'(bus0.branch_cnt_o), 32'd8);
    check("sat_mcnt", 32'(bus0.mispred_cnt_o), 32'd5);
    check("bimodal_hist", 32'(bus0.pred_hist_o), 32'd0);

    // Aliasing on idx 0 with different tags
    lookup(0, 32'h200);
    check("alias_hit", 32'(bus0.pred_hit_o), 32'd0);
    check("alias_target", bus0.pred_target_o, 32'h204);
    doUpdate(0, 32'h200, 6'd0, 1'b1, 32'h40, 1'b0);
    lookup(0, 32'h200);
    check("alias2_hit", 32'(bus0.pred_hit_o), 32'd1);
    check("alias2_target", bus0.pred_target_o, 32'h40);
    lookup(0, 32'h100);
    check("alias_old_hit", 32'(bus0.pred_hit_o), 32'd0);

    // Same-cycle lookup and update: old contents, then new
    @(negedge clk);
    bus0.update_valid_i = 1'b1; bus0.update_pc_i = 32'h100; bus0.update_hist_i = '0;
    bus0.update_taken_i = 1'b1; bus0.update_target_i = 32'h80;
    bus0.update_pred_taken_i = 1'b0;
    lookup(0, 32'h100);
    check("rdold_hit", 32'(bus0.pred_hit_o), 32'd0);
    check("rdold_target", bus0.pred_target_o, 32'h104);
    @(posedge clk);
    #1;
    bus0.update_valid_i = 1'b0;
    #1;
    check("rdnew_hit", 32'(bus0.pred_hit_o), 32'd1);
    check("rdnew_target", bus0.pred_target_o, 32'h80);
    check("rdnew_bcnt", 32'(bus0.branch_cnt_o), 32'd10);
    check("rdnew_mcnt", 32'(bus0.mispred_cnt_o), 32'd7);

    // gshare: history shifts in outcomes and perturbs the index
    doUpdate(1, 32'h400, 6'h00, 1'b1, 32'h10, 1'b0);
    doUpdate(1, 32'h400, 6'h01, 1'b1, 32'h10, 1'b0);
    doUpdate(1, 32'h400, 6'h03, 1'b1, 32'h10, 1'b0);
    lookup(1, 32'h400);
    check("g_hist3", 32'(bus1.pred_hist_o), 32'h07);
    check("g_idx7_hit", 32'(bus1.pred_hit_o), 32'd0);
    check("g_idx7_target", bus1.pred_target_o, 32'h404);
    doUpdate(1, 32'h400, 6'h07, 1'b1, 32'h10, 1'b0);
    lookup(1, 32'h400);
    check("g_hist4", 32'(bus1.pred_hist_o), 32'h0F);
    check("g_idxF_hit", 32'(bus1.pred_hit_o), 32'd0);
    doUpdate(1, 32'h400, 6'h0F, 1'b0, 32'h0, 1'b0);
    lookup(1, 32'h400);
    check("g_hist5", 32'(bus1.pred_hist_o), 32'h1E);
    check("g_bcnt", 32'(bus1.branch_cnt_o), 32'd5);

    // Narrow statistics saturate
    for (int i = 0; i < 20; i++) doUpdate(2, 32'h100, 6'd0, 1'b1, 32'h80, 1'b0);
    check("sat4_mcnt", 32'(bus2.mispred_cnt_o), 32'hF);
    check("sat4_bcnt", 32'(bus2.branch_cnt_o), 32'hF);

    // Reset wins over a concurrent update
    @(negedge clk);
    rst = 1'b0;
    bus0.update_valid_i = 1'b1; bus0.update_pc_i = 32'h300; bus0.update_taken_i = 1'b1;
    bus0.update_target_i = 32'h99; bus0.update_pred_taken_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus0.update_valid_i = 1'b0;
    lookup(0, 32'h300);
    check("rstupd_hit", 32'(bus0.pred_hit_o), 32'd0);
    check("rstupd_target", bus0.pred_target_o, 32'h304);
    check("rstupd_bcnt", 32'(bus0.branch_cnt_o), 32'd0);
    check("rstupd_mcnt", 32'(bus0.mispred_cnt_o), 32'd0);
    lookup(0, 32'h100);
    check("rstupd_old_hit", 32'(bus0.pred_hit_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
